// File: rtl/row_mac_accumulator.sv
// Row-by-row multiply-accumulate over N_OUT signed lanes, one row per accepted load.
// Define ACC_SAT_EN to saturate lanes and report a sticky ovf; otherwise lanes wrap.
module row_mac_accumulator #(
   parameter int unsigned N_OUT  = 100,
   parameter int unsigned DATA_W = 16,
   parameter int unsigned PIX_W  = 1,
   parameter int unsigned ACC_W  = 16,
   parameter int unsigned N_ROWS = 784
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          start,
   input  logic                          load,
   input  logic [PIX_W-1:0]              pixel,
   input  logic [N_OUT*DATA_W-1:0]       add_row,
   output logic                          ready,
   output logic                          complete,
   output logic [$clog2(N_ROWS+1)-1:0]   row_cnt,
   output logic                          ovf,
   output logic [N_OUT*ACC_W-1:0]        result
);

   localparam int unsigned CNT_W  = $clog2(N_ROWS + 1);
   localparam int unsigned PROD_W = DATA_W + PIX_W + 1;

   typedef enum logic [1:0] {StIdle, StAccum, StDone} state_t;

   state_t                   state_q, state_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic [N_OUT*ACC_W-1:0]   acc_q, acc_d;
   logic [N_OUT*ACC_W-1:0]   lane_next;
   logic                     accept;

   assign accept = (state_q == StAccum) && load && !start;

`ifdef ACC_SAT_EN
   localparam int unsigned SUM_W = ACC_W + 1;
   logic [N_OUT-1:0] lane_clamp;
   logic             ovf_q;
`endif

   for (genvar i = 0; i < N_OUT; i++) begin : g_lane
      logic signed [PROD_W-1:0] a_ext, p_ext, prod;
      logic signed [ACC_W-1:0]  prod_a, acc_l;

      // Pixel is unsigned: widen with a zero MSB so the signed multiply keeps it positive.
      assign a_ext  = PROD_W'($signed(add_row[i*DATA_W +: DATA_W]));
      assign p_ext  = PROD_W'({1'b0, pixel});
      assign prod   = a_ext * p_ext;
      assign prod_a = ACC_W'(prod);
      assign acc_l  = acc_q[i*ACC_W +: ACC_W];

`ifdef ACC_SAT_EN
      logic signed [SUM_W-1:0] sum;
      assign sum = SUM_W'(prod_a) + SUM_W'(acc_l);
      // Top two bits disagree exactly when the true sum left the ACC_W range.
      assign lane_clamp[i] = sum[ACC_W] ^ sum[ACC_W-1];
      assign lane_next[i*ACC_W +: ACC_W] =
         !lane_clamp[i] ? sum[ACC_W-1:0] :
         sum[ACC_W]     ? {1'b1, {(ACC_W-1){1'b0}}} :
                          {1'b0, {(ACC_W-1){1'b1}}};
`else
      assign lane_next[i*ACC_W +: ACC_W] = prod_a + acc_l;
`endif
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      if (start) begin
         state_d = StAccum;
         cnt_d   = '0;
         acc_d   = '0;
      end else if (accept) begin
         cnt_d = cnt_q + 1'b1;
         acc_d = lane_next;
         if (cnt_q == CNT_W'(N_ROWS - 1)) begin
            state_d = StDone;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         acc_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
      end
   end

`ifdef ACC_SAT_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf_q <= 1'b0;
      end else if (start) begin
         ovf_q <= 1'b0;
      end else if (accept && (|lane_clamp)) begin
         ovf_q <= 1'b1;
      end
   end
   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign ready    = (state_q == StAccum);
   assign complete = (state_q == StDone);
   assign row_cnt  = cnt_q;
   assign result   = acc_q;

endmodule
